// File: rtl/pkg_breg.sv
// Shared types and constants for the register-bank write-back stage.
package pkg_breg;

  typedef enum logic {
    OCIOSO = 1'b0,
    ESPERA = 1'b1
  } estado_e;

  localparam int unsigned FONTE_ULA     = 0;
  localparam int unsigned FONTE_MEM     = 1;
  localparam int unsigned FONTE_PC1     = 2;
  localparam int unsigned FONTE_ENTRADA = 3;
  localparam int unsigned FONTE_STATUS  = 4;

  // Select width for n sources; a single source still gets a 1-bit select.
  function automatic int unsigned larg_sel(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_n_fontes.sv
// N-to-1 selector over a flattened source bus; out-of-range select yields zero.
module mux_n_fontes
  import pkg_breg::*;
#(
  parameter int unsigned LARGURA    = 32,
  parameter int unsigned NUM_FONTES = 5
) (
  input  logic [larg_sel(NUM_FONTES)-1:0] sel_i,
  input  logic [NUM_FONTES*LARGURA-1:0]   fontes_i,
  output logic [LARGURA-1:0]              dado_c_o
);

  localparam int unsigned LARG_SEL = larg_sel(NUM_FONTES);

  always_comb begin
    dado_c_o = '0;
    for (int k = 0; k < NUM_FONTES; k++) begin
      if (sel_i == LARG_SEL'(k)) dado_c_o = fontes_i[k*LARGURA +: LARGURA];
    end
  end

endmodule

// File: rtl/escrita_breg_param.sv
// Write-back stage: selects one of N sources, registers data/address/enable,
// and stalls on the external-input source until its data is valid or times out.
module escrita_breg_param
  import pkg_breg::*;
#(
  parameter int unsigned LARGURA     = 32,
  parameter int unsigned NUM_FONTES  = 5,
  parameter int unsigned IDX_ENTRADA = 3,
  parameter int unsigned LARG_END    = 5,
  parameter int unsigned TIMEOUT     = 0,
  parameter bit          PROTEGE_R0  = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            valido,
  input  logic [larg_sel(NUM_FONTES)-1:0] controle,
  input  logic [LARG_END-1:0]             end_dest,
  input  logic [NUM_FONTES*LARGURA-1:0]   fontes,
  input  logic                            entrada_valida,
  output logic                            entrada_ack,
  output logic                            parada,
  output logic                            we_breg,
  output logic [LARG_END-1:0]             end_breg,
  output logic [LARGURA-1:0]              dado_breg,
  output logic                            erro_sel
);

  localparam int unsigned LARG_SEL = larg_sel(NUM_FONTES);
  localparam int unsigned CNT_W    = $clog2(TIMEOUT + 2);
  // The incremented count is compared, so the request cycle counts as a wait cycle.
  localparam int unsigned LIMITE   = (TIMEOUT > 1) ? (TIMEOUT - 1) : 1;
  localparam logic [LARG_SEL:0] NUM_FONTES_EXT = (LARG_SEL + 1)'(NUM_FONTES);

  estado_e               state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [LARG_END-1:0]   end_lat_q, end_lat_d;
  logic                  we_q, we_d;
  logic                  ack_q, ack_d;
  logic                  erro_q, erro_d;
  logic [LARG_END-1:0]   end_q, end_d;
  logic [LARGURA-1:0]    dado_q, dado_d;
  logic                  parada_c;
  logic [LARG_SEL-1:0]   sel_mux;
  logic [LARGURA-1:0]    dado_mux;
  logic                  sel_ok;
  logic                  eh_entrada;
  logic                  timeout_hit;

  function automatic logic pode_escrever(input logic [LARG_END-1:0] a);
    return !(PROTEGE_R0 && (a == '0));
  endfunction

  // While waiting, the mux is pinned to the external-input source.
  assign sel_mux     = (state_q == ESPERA) ? LARG_SEL'(IDX_ENTRADA) : controle;
  assign sel_ok      = ({1'b0, controle} < NUM_FONTES_EXT);
  assign eh_entrada  = (controle == LARG_SEL'(IDX_ENTRADA));
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc >= CNT_W'(LIMITE));

  mux_n_fontes #(
    .LARGURA    (LARGURA),
    .NUM_FONTES (NUM_FONTES)
  ) u_mux (
    .sel_i    (sel_mux),
    .fontes_i (fontes),
    .dado_c_o (dado_mux)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    end_lat_d = end_lat_q;
    we_d      = 1'b0;
    ack_d     = 1'b0;
    erro_d    = 1'b0;
    end_d     = end_q;
    dado_d    = dado_q;
    parada_c  = 1'b0;
    case (state_q)
      OCIOSO: begin
        if (valido) begin
          if (!sel_ok) begin
            erro_d = 1'b1;
          end else if (!eh_entrada) begin
            dado_d = dado_mux;
            end_d  = end_dest;
            we_d   = pode_escrever(end_dest);
          end else if (entrada_valida) begin
            dado_d = dado_mux;
            end_d  = end_dest;
            we_d   = pode_escrever(end_dest);
            ack_d  = 1'b1;
          end else begin
            end_lat_d = end_dest;
            cnt_d     = '0;
            state_d   = ESPERA;
            parada_c  = 1'b1;
          end
        end
      end
      ESPERA: begin
        parada_c = 1'b1;
        cnt_d    = cnt_inc;
        // Valid data takes priority over a coincident timeout.
        if (entrada_valida) begin
          dado_d  = dado_mux;
          end_d   = end_lat_q;
          we_d    = pode_escrever(end_lat_q);
          ack_d   = 1'b1;
          state_d = OCIOSO;
        end else if (timeout_hit) begin
          erro_d  = 1'b1;
          state_d = OCIOSO;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OCIOSO;
      cnt_q     <= '0;
      end_lat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      end_lat_q <= end_lat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      ack_q  <= 1'b0;
      erro_q <= 1'b0;
      end_q  <= '0;
      dado_q <= '0;
    end else begin
      we_q   <= we_d;
      ack_q  <= ack_d;
      erro_q <= erro_d;
      end_q  <= end_d;
      dado_q <= dado_d;
    end
  end

  assign parada      = parada_c;
  assign we_breg     = we_q;
  assign entrada_ack = ack_q;
  assign erro_sel    = erro_q;
  assign end_breg    = end_q;
  assign dado_breg   = dado_q;

endmodule
